// File: rtl/nwcc_shift_register_counter.sv
// nwcc_shift_register_counter: neutron coincidence counter with shift-register R+A and A gates
// Ports: clk_1mhz clock, reset_ip async active-high reset, pulse_ip async detector level,
//        start_ip/abort_ip 1-cycle strobes, meas_cycles_ip counting period (0 acts as 1),
//        busy_op high in COUNT/DRAIN, done_op 1-cycle strobe with latched total/ra/a counts,
//        ovf_op latched saturation flag.
// Build option: NWCC_SAT_EN makes accumulators saturate and drives ovf_op; otherwise they wrap.
module nwcc_shift_register_counter #(
   parameter int CNT_W      = 24,
   parameter int PREDELAY   = 4,
   parameter int GATE       = 64,
   parameter int LONG_DELAY = 1024,
   parameter int MEAS_W     = 20
) (
   input  logic              clk_1mhz,
   input  logic              reset_ip,
   input  logic              pulse_ip,
   input  logic              start_ip,
   input  logic              abort_ip,
   input  logic [MEAS_W-1:0] meas_cycles_ip,
   output logic              busy_op,
   output logic              done_op,
   output logic [CNT_W-1:0]  total_count_op,
   output logic [CNT_W-1:0]  ra_count_op,
   output logic [CNT_W-1:0]  a_count_op,
   output logic              ovf_op
);
   localparam int DEPTH     = PREDELAY + GATE;
   localparam int DRAIN_LEN = LONG_DELAY + DEPTH;
   localparam int OCC_W     = $clog2(GATE + 1);
   localparam int TMR_W     = MEAS_W > $clog2(DRAIN_LEN + 1) ? MEAS_W : $clog2(DRAIN_LEN + 1);
   typedef enum logic [1:0] {IDLE, COUNT, DRAIN, DONE} state_t;
   state_t                state;
   logic [2:0]            sync;
   logic                  evt;
   logic [DEPTH-1:0]      gate_sr;
   logic [LONG_DELAY-1:0] long_sr;
   logic [OCC_W-1:0]      occ;
   logic [TMR_W-1:0]      timer;
   logic [CNT_W-1:0]      total_acc, ra_acc, a_acc;
   logic                  ovf_acc;
   logic                  ev_in;
   // tap[k] is the event from k cycles ago; tap[0] is this cycle's gated event
   logic [DEPTH:0]        gate_tap;
   logic [LONG_DELAY:0]   long_tap;
   logic [OCC_W-1:0]      occ_nxt;
   logic [CNT_W-1:0]      total_nxt, ra_nxt, a_nxt;
   logic                  ovf_nxt;
   always_comb begin
      ev_in    = evt && state == COUNT;
      gate_tap = {gate_sr, ev_in};
      long_tap = {long_sr, ev_in};
      occ_nxt  = occ + OCC_W'(gate_tap[PREDELAY]) - OCC_W'(gate_tap[DEPTH]);
   end
`ifdef NWCC_SAT_EN
   localparam int SUM_W = (CNT_W > OCC_W ? CNT_W : OCC_W) + 1;
   localparam logic [SUM_W-1:0] ACC_MAX = {{(SUM_W-CNT_W){1'b0}}, {CNT_W{1'b1}}};
   logic [SUM_W-1:0] total_sum, ra_sum, a_sum;
   always_comb begin
      total_sum = SUM_W'(total_acc) + SUM_W'(ev_in);
      ra_sum    = SUM_W'(ra_acc) + (ev_in ? SUM_W'(occ) : '0);
      a_sum     = SUM_W'(a_acc) + (long_tap[LONG_DELAY] ? SUM_W'(occ) : '0);
      total_nxt = total_sum > ACC_MAX ? '1 : total_sum[CNT_W-1:0];
      ra_nxt    = ra_sum > ACC_MAX ? '1 : ra_sum[CNT_W-1:0];
      a_nxt     = a_sum > ACC_MAX ? '1 : a_sum[CNT_W-1:0];
      ovf_nxt   = ovf_acc || total_sum > ACC_MAX || ra_sum > ACC_MAX || a_sum > ACC_MAX;
   end
`else
   always_comb begin
      total_nxt = total_acc + CNT_W'(ev_in);
      ra_nxt    = ra_acc + (ev_in ? CNT_W'(occ) : '0);
      a_nxt     = a_acc + (long_tap[LONG_DELAY] ? CNT_W'(occ) : '0);
      ovf_nxt   = 1'b0;
   end
`endif
   always_ff @(posedge clk_1mhz or posedge reset_ip) begin
      if (reset_ip) begin
         state          <= IDLE;
         sync           <= '0;
         evt            <= 1'b0;
         gate_sr        <= '0;
         long_sr        <= '0;
         occ            <= '0;
         timer          <= '0;
         total_acc      <= '0;
         ra_acc         <= '0;
         a_acc          <= '0;
         ovf_acc        <= 1'b0;
         busy_op        <= 1'b0;
         done_op        <= 1'b0;
         total_count_op <= '0;
         ra_count_op    <= '0;
         a_count_op     <= '0;
         ovf_op         <= 1'b0;
      end else begin
         sync      <= {sync[1:0], pulse_ip};
         evt       <= sync[1] && !sync[2];
         gate_sr   <= gate_tap[DEPTH-1:0];
         long_sr   <= long_tap[LONG_DELAY-1:0];
         occ       <= occ_nxt;
         total_acc <= total_nxt;
         ra_acc    <= ra_nxt;
         a_acc     <= a_nxt;
         ovf_acc   <= ovf_nxt;
         done_op   <= 1'b0;
         case (state)
            IDLE: if (start_ip) begin
               state     <= COUNT;
               busy_op   <= 1'b1;
               timer     <= meas_cycles_ip == '0 ? TMR_W'(1) : TMR_W'(meas_cycles_ip);
               gate_sr   <= '0;
               long_sr   <= '0;
               occ       <= '0;
               total_acc <= '0;
               ra_acc    <= '0;
               a_acc     <= '0;
               ovf_acc   <= 1'b0;
            end
            COUNT: if (abort_ip) begin
               state   <= IDLE;
               busy_op <= 1'b0;
            end else if (timer == TMR_W'(1)) begin
               state <= DRAIN;
               timer <= TMR_W'(DRAIN_LEN);
            end else timer <= timer - TMR_W'(1);
            DRAIN: if (abort_ip) begin
               state   <= IDLE;
               busy_op <= 1'b0;
            end else if (timer == TMR_W'(1)) begin
               state   <= DONE;
               busy_op <= 1'b0;
            end else timer <= timer - TMR_W'(1);
            DONE: begin
               state          <= IDLE;
               done_op        <= 1'b1;
               total_count_op <= total_acc;
               ra_count_op    <= ra_acc;
               a_count_op     <= a_acc;
               ovf_op         <= ovf_acc;
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_nwcc_shift_register_counter.sv
// tb_nwcc_shift_register_counter: vector table, corner sequences and random runs against a pair-counting model
module tb_nwcc_shift_register_counter;
   localparam int P = 4, G = 16, L = 64, CW = 24, SW = 4, MW = 20;
   localparam int TAIL = L + P + G + 2;
   logic clk_1mhz = 1'b0, reset_ip = 1'b1, pulse_ip = 1'b0, start_ip = 1'b0, abort_ip = 1'b0;
   logic [MW-1:0] meas_cycles_ip = '0;
   logic busy_op, done_op, ovf_op, busy4, done4, ovf4;
   logic [CW-1:0] total_count_op, ra_count_op, a_count_op;
   logic [SW-1:0] tot4, ra4, a4;
   int n_vec = 0, n_bad = 0;
   bit rise [0:1023];
   bit wave [0:1023];
   typedef struct {int gap; int tot; int ra; int a;} vec_t;
   vec_t vecs [10];
   always #5 clk_1mhz = ~clk_1mhz;
   nwcc_shift_register_counter #(.CNT_W(CW), .PREDELAY(P), .GATE(G), .LONG_DELAY(L), .MEAS_W(MW)) dut (
      .clk_1mhz(clk_1mhz), .reset_ip(reset_ip), .pulse_ip(pulse_ip), .start_ip(start_ip),
      .abort_ip(abort_ip), .meas_cycles_ip(meas_cycles_ip), .busy_op(busy_op), .done_op(done_op),
      .total_count_op(total_count_op), .ra_count_op(ra_count_op), .a_count_op(a_count_op), .ovf_op(ovf_op));
   nwcc_shift_register_counter #(.CNT_W(SW), .PREDELAY(P), .GATE(G), .LONG_DELAY(L), .MEAS_W(MW)) dut4 (
      .clk_1mhz(clk_1mhz), .reset_ip(reset_ip), .pulse_ip(pulse_ip), .start_ip(start_ip),
      .abort_ip(abort_ip), .meas_cycles_ip(meas_cycles_ip), .busy_op(busy4), .done_op(done4),
      .total_count_op(tot4), .ra_count_op(ra4), .a_count_op(a4), .ovf_op(ovf4));
   task automatic chk(input string name, input longint act, input longint exp);
      n_vec++;
      if (act != exp) begin
         n_bad++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask
   // Counts ordered event pairs whose separation falls inside the R+A or A gate window.
   function automatic void model(input int offs[$], input int n, output int tot, output int ra, output int a);
      int t[$];
      foreach (offs[i]) if (offs[i] + 3 <= n) t.push_back(offs[i]);
      tot = t.size();
      ra = 0;
      a = 0;
      foreach (t[i]) foreach (t[j]) begin
         if (t[j] - t[i] >= P + 1 && t[j] - t[i] <= P + G) ra++;
         if (t[j] - t[i] >= L - P - G && t[j] - t[i] <= L - P - 1) a++;
      end
   endfunction
   function automatic longint narrow(input longint x);
`ifdef NWCC_SAT_EN
      return x > (1 << SW) - 1 ? (1 << SW) - 1 : x;
`else
      return x % (1 << SW);
`endif
   endfunction
   function automatic longint ovf_exp(input int tot, input int ra, input int a);
`ifdef NWCC_SAT_EN
      return (tot > (1 << SW) - 1 || ra > (1 << SW) - 1 || a > (1 << SW) - 1) ? 1 : 0;
`else
      return (tot + ra + a) < 0 ? 1 : 0;
`endif
   endfunction
   task automatic check_outputs(input string tag, input int tot, input int ra, input int a);
      chk({tag, " total"}, total_count_op, tot);
      chk({tag, " ra"}, ra_count_op, ra);
      chk({tag, " a"}, a_count_op, a);
      chk({tag, " ovf"}, ovf_op, 0);
      chk({tag, " total4"}, tot4, narrow(tot));
      chk({tag, " ra4"}, ra4, narrow(ra));
      chk({tag, " a4"}, a4, narrow(a));
      chk({tag, " ovf4"}, ovf4, ovf_exp(tot, ra, a));
   endtask
   // Drives one start at k=0 (plus an ignored start at k=5); k counts cycles from the start cycle.
   task automatic run(input int meas, input int offs[$], input int ncyc, input int abort_at,
                      input int reset_at, output int done_k, output bit busy1);
      foreach (rise[i]) begin
         rise[i] = 1'b0;
         wave[i] = 1'b0;
      end
      foreach (offs[i]) rise[offs[i]] = 1'b1;
      foreach (rise[i]) if (rise[i]) begin
         wave[i] = 1'b1;
         if (i + 2 < 1024 && !rise[i+2]) wave[i+1] = 1'b1;
      end
      meas_cycles_ip = MW'(meas);
      done_k = -1;
      busy1 = 1'b0;
      for (int k = 0; k < ncyc; k++) begin
         @(negedge clk_1mhz);
         if (done_op && done_k < 0) done_k = k;
         if (k == 1) busy1 = busy_op;
         start_ip = (k == 0 || k == 5);
         abort_ip = (k == abort_at);
         reset_ip = (k == reset_at);
         pulse_ip = k < 1024 ? wave[k] : 1'b0;
      end
      @(negedge clk_1mhz);
      start_ip = 1'b0;
      abort_ip = 1'b0;
      reset_ip = 1'b0;
      pulse_ip = 1'b0;
   endtask
   initial begin
      int q[$];
      int dk, n, o, et, er, ea;
      bit b1;
      vecs = '{'{10, 2, 1, 0}, '{4, 2, 0, 0}, '{5, 2, 1, 0}, '{20, 2, 1, 0}, '{21, 2, 0, 0},
               '{50, 2, 0, 1}, '{43, 2, 0, 0}, '{44, 2, 0, 1}, '{59, 2, 0, 1}, '{60, 2, 0, 0}};
      repeat (3) @(negedge clk_1mhz);
      chk("reset busy", busy_op, 0);
      chk("reset done", done_op, 0);
      check_outputs("reset", 0, 0, 0);
      reset_ip = 1'b0;
      repeat (2) @(negedge clk_1mhz);
      chk("idle busy", busy_op, 0);
      foreach (vecs[i]) begin
         q = {10, 10 + vecs[i].gap};
         run(500, q, 500 + TAIL + 6, -1, -1, dk, b1);
         chk($sformatf("gap%0d done_k", vecs[i].gap), dk, 500 + TAIL);
         chk($sformatf("gap%0d busy", vecs[i].gap), b1, 1);
         chk($sformatf("gap%0d busy_after", vecs[i].gap), busy_op, 0);
         check_outputs($sformatf("gap%0d", vecs[i].gap), vecs[i].tot, vecs[i].ra, vecs[i].a);
      end
      q = {47, 97};
      run(100, q, 100 + TAIL + 6, -1, -1, dk, b1);
      chk("lastcycle done_k", dk, 100 + TAIL);
      check_outputs("lastcycle", 2, 0, 1);
      q = {48, 98};
      run(100, q, 100 + TAIL + 6, -1, -1, dk, b1);
      check_outputs("pastend", 1, 0, 0);
      q.delete();
      run(0, q, TAIL + 10, -1, -1, dk, b1);
      chk("meas0 done_k", dk, 1 + TAIL);
      check_outputs("meas0", 0, 0, 0);
      q.delete();
      for (int i = 0; i < 30; i++) q.push_back(10 + 2 * i);
      model(q, 500, et, er, ea);
      run(500, q, 500 + TAIL + 6, -1, -1, dk, b1);
      check_outputs("burst2", et, er, ea);
      q.delete();
      for (int i = 0; i < 8; i++) q.push_back(10 + 3 * i);
      run(500, q, 500 + TAIL + 6, -1, -1, dk, b1);
      check_outputs("burst3", 8, 20, 0);
      for (int r = 0; r < 6; r++) begin
         n = $urandom_range(30, 400);
         q.delete();
         o = $urandom_range(0, 20);
         while (o < n + 5) begin
            q.push_back(o);
            o += $urandom_range(2, 70);
         end
         model(q, n, et, er, ea);
         run(n, q, n + TAIL + 6, -1, -1, dk, b1);
         chk($sformatf("rand%0d done_k", r), dk, n + TAIL);
         check_outputs($sformatf("rand%0d", r), et, er, ea);
      end
      q = {10, 20};
      run(500, q, 500 + TAIL + 6, -1, -1, dk, b1);
      check_outputs("pre_abort", 2, 1, 0);
      q = {10, 60, 100};
      run(500, q, 500 + TAIL + 6, 150, -1, dk, b1);
      chk("abort done_k", dk, -1);
      chk("abort busy", busy_op, 0);
      check_outputs("abort", 2, 1, 0);
      q = {5, 30};
      run(50, q, 50 + TAIL + 6, 50, -1, dk, b1);
      chk("abort_expiry done_k", dk, -1);
      check_outputs("abort_expiry", 2, 1, 0);
      q = {10, 20};
      run(100, q, 100 + TAIL + 6, 150, -1, dk, b1);
      chk("abort_drain done_k", dk, -1);
      check_outputs("abort_drain", 2, 1, 0);
      run(100, q, 100 + TAIL + 6, -1, 150, dk, b1);
      chk("reset_drain done_k", dk, -1);
      chk("reset_drain busy", busy_op, 0);
      check_outputs("reset_drain", 0, 0, 0);
      q = {10, 60};
      run(200, q, 200 + TAIL + 6, -1, -1, dk, b1);
      chk("recover done_k", dk, 200 + TAIL);
      check_outputs("recover", 2, 0, 1);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end
endmodule
